// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: drives one convolution engine over every (filter, input map) pair,
// accumulating per-map results in a partial-sum buffer and streaming each finished output map.
module conv_layer_sequencer #(
  parameter int DATA_W      = 16,
  parameter int MAX_IMG     = 32,
  parameter int MAX_FILT    = 5,
  parameter int MAX_MAPS    = 16,
  parameter int MAX_FILTERS = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [15:0]       i_imageSize,
  input  logic [15:0]       i_filterSize,
  input  logic [15:0]       i_numMaps,
  input  logic [15:0]       i_numFilters,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_eng_start,
  output logic [15:0]       o_eng_map_idx,
  output logic [15:0]       o_eng_filter_idx,
  input  logic              i_eng_out_valid,
  input  logic [DATA_W-1:0] i_eng_out_data,
  input  logic              i_eng_done,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_last,
  output logic [15:0]       o_out_filter_idx
);

  localparam int DEPTH = MAX_IMG * MAX_IMG;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_engStart;
  logic [15:0]       r_numMaps;
  logic [15:0]       r_numFilters;
  logic [CW-1:0]     r_pixTotal;
  logic [15:0]       r_mapIdx;
  logic [15:0]       r_filterIdx;
  logic [CW-1:0]     r_wrIdx;
  logic [CW-1:0]     r_rdIdx;
  logic              r_outValid;
  logic              r_outLast;
  logic [DATA_W-1:0] r_outData;

  logic [DATA_W-1:0] r_psum [DEPTH];

  logic              w_cfgBad;
  logic [CW-1:0]     w_side;
  logic [CW-1:0]     w_area;
  logic              w_pixIn;
  logic              w_wrEn;
  logic [CW-1:0]     w_wrNext;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_sat;
  logic [DATA_W-1:0] w_wrData;
  logic [DATA_W-1:0] w_rdData;
  logic              w_accept;
  logic              w_fetch;

  assign w_cfgBad = (i_filterSize == 16'd0) || (i_filterSize > i_imageSize) ||
                    (i_imageSize > 16'(MAX_IMG)) || (i_filterSize > 16'(MAX_FILT)) ||
                    (i_numMaps == 16'd0) || (i_numMaps > 16'(MAX_MAPS)) ||
                    (i_numFilters == 16'd0) || (i_numFilters > 16'(MAX_FILTERS));

  // Output side P = N-K+1 only matters for accepted configs, where P*P fits the buffer.
  assign w_side = CW'(i_imageSize - i_filterSize + 16'd1);
  assign w_area = w_side * w_side;

  // Pixels past P*P are dropped rather than wrapping into the buffer.
  assign w_pixIn  = (r_state == S_RUN) && i_eng_out_valid;
  assign w_wrEn   = w_pixIn && (r_wrIdx < r_pixTotal);
  assign w_wrNext = r_wrIdx + CW'(w_wrEn);

  assign w_old    = r_psum[r_wrIdx[AW-1:0]];
  assign w_rdData = r_psum[r_rdIdx[AW-1:0]];

  always_comb begin
    w_sum = {w_old[DATA_W-1], w_old} + {i_eng_out_data[DATA_W-1], i_eng_out_data};
    if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
      w_sat = w_sum[DATA_W] ? SAT_MIN : SAT_MAX;
    end else begin
      w_sat = w_sum[DATA_W-1:0];
    end
  end

  assign w_wrData = (r_mapIdx == 16'd0) ? i_eng_out_data : w_sat;

  assign w_accept = r_outValid && i_out_ready;
  assign w_fetch  = (r_rdIdx < r_pixTotal) && (!r_outValid || w_accept);

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_wrEn) begin
      r_psum[r_wrIdx[AW-1:0]] <= w_wrData;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_engStart   <= 1'b0;
      r_numMaps    <= '0;
      r_numFilters <= '0;
      r_pixTotal   <= '0;
      r_mapIdx     <= '0;
      r_filterIdx  <= '0;
      r_wrIdx      <= '0;
      r_rdIdx      <= '0;
      r_outValid   <= 1'b0;
      r_outLast    <= 1'b0;
      r_outData    <= '0;
    end else begin
      r_engStart <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_numMaps    <= i_numMaps;
            r_numFilters <= i_numFilters;
            r_pixTotal   <= w_area;
            r_mapIdx     <= '0;
            r_filterIdx  <= '0;
            r_error      <= w_cfgBad;
            r_busy       <= 1'b1;
            if (w_cfgBad) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          r_engStart <= 1'b1;
          r_wrIdx    <= '0;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          r_wrIdx <= w_wrNext;
          if (w_pixIn && !w_wrEn) begin
            r_error <= 1'b1;
          end
          // The pixel arriving with eng_done is already included in w_wrNext.
          if (i_eng_done) begin
            if (w_wrNext != r_pixTotal) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (r_mapIdx < r_numMaps - 16'd1) begin
              r_mapIdx <= r_mapIdx + 16'd1;
              r_state  <= S_LAUNCH;
            end else begin
              r_rdIdx <= '0;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_fetch) begin
            r_outValid <= 1'b1;
            r_outData  <= w_rdData;
            r_outLast  <= (r_rdIdx == r_pixTotal - CW'(1));
            r_rdIdx    <= r_rdIdx + CW'(1);
          end else if (w_accept) begin
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
          end
          if (w_accept && r_outLast) begin
            if (r_filterIdx < r_numFilters - 16'd1) begin
              r_filterIdx <= r_filterIdx + 16'd1;
              r_mapIdx    <= '0;
              r_state     <= S_LAUNCH;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_error          = r_error;
  assign o_eng_start      = r_engStart;
  assign o_eng_map_idx    = r_mapIdx;
  assign o_eng_filter_idx = r_filterIdx;
  assign o_out_valid      = r_outValid;
  assign o_out_data       = r_outData;
  assign o_out_last       = r_outLast;
  assign o_out_filter_idx = r_filterIdx;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: emulates the convolution engine and downstream sink, and checks
// every streamed pixel against a per-layer arithmetic model of the accumulated maps.
module tb_conv_layer_sequencer;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [15:0] i_imageSize, i_filterSize, i_numMaps, i_numFilters;
  logic        o_busy, o_done, o_error, o_eng_start;
  logic [15:0] o_eng_map_idx, o_eng_filter_idx, o_out_filter_idx;
  logic        i_eng_out_valid, i_eng_done, o_out_valid, i_out_ready, o_out_last;
  logic [15:0] i_eng_out_data, o_out_data;

  conv_layer_sequencer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_imageSize(i_imageSize), .i_filterSize(i_filterSize),
    .i_numMaps(i_numMaps), .i_numFilters(i_numFilters),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_eng_start(o_eng_start), .o_eng_map_idx(o_eng_map_idx), .o_eng_filter_idx(o_eng_filter_idx),
    .i_eng_out_valid(i_eng_out_valid), .i_eng_out_data(i_eng_out_data), .i_eng_done(i_eng_done),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_out_last(o_out_last), .o_out_filter_idx(o_out_filter_idx)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [15:0] data; bit last; int filt; } outRec;
  typedef struct {
    int n, k, m, f, ovr, mode, step, rdy, expErr, expStarts, expPix;
    logic [15:0] expLast; bit chkLast;
  } vecT;

  int testsRun = 0, testsFailed = 0;
  int cyc = 0;
  int cfgM, cfgF, cfgP2, pixOverride, dataMode, readyMode;
  int patVal [16];
  int mdl [1024];
  int expPair, engStarts, engPix, pixOut, firstStartCyc, startCyc;
  logic [15:0] lastOut;
  bit engKill;
  outRec expQ [$];
  vecT vecs [$];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Engine emulation: pairs arrive filter-major, map-minor; emits pixels with random gaps.
  task automatic runEngine();
    int c, f, npix;
    logic [15:0] d;
    bit combine;
    c = expPair % cfgM;
    f = expPair / cfgM;
    checkOutput("eng_map_idx", o_eng_map_idx, c);
    checkOutput("eng_filter_idx", o_eng_filter_idx, f);
    expPair++;
    npix = (pixOverride >= 0) ? pixOverride : cfgP2;
    combine = 1'($urandom_range(0, 1));
    for (int i = 0; i < npix; i++) begin
      repeat ($urandom_range(0, 1)) begin
        i_eng_out_valid = 1'b0;
        @(posedge i_clk); #1;
        if (engKill) begin i_eng_out_valid = 1'b0; i_eng_done = 1'b0; return; end
      end
      d = (dataMode == 0) ? 16'($urandom) : 16'(patVal[c]);
      i_eng_out_valid = 1'b1;
      i_eng_out_data  = d;
      engPix++;
      if (i < cfgP2) mdl[i] = (c == 0) ? int'($signed(d)) : sat16(mdl[i] + int'($signed(d)));
      if (i == npix - 1 && combine) break;
      @(posedge i_clk); #1;
      i_eng_out_valid = 1'b0;
      if (engKill) begin i_eng_done = 1'b0; return; end
    end
    if (npix >= cfgP2 && c == cfgM - 1)
      for (int i = 0; i < cfgP2; i++) expQ.push_back('{16'(mdl[i]), (i == cfgP2 - 1), f});
    i_eng_done = 1'b1;
    checkOutput("eng_map_idx_stable", o_eng_map_idx, c);
    @(posedge i_clk); #1;
    i_eng_out_valid = 1'b0;
    i_eng_done      = 1'b0;
  endtask

  initial begin
    i_eng_out_valid = 1'b0; i_eng_done = 1'b0; i_eng_out_data = '0;
    forever begin
      @(posedge i_clk); #1;
      if (o_eng_start && !engKill) begin
        engStarts++;
        if (engStarts == 1) firstStartCyc = cyc;
        runEngine();
      end
    end
  end

  // Downstream sink: drives out_ready per mode and scores each accepted pixel.
  initial begin
    outRec r;
    bit rdy, prevStall;
    logic [15:0] prevData;
    i_out_ready = 1'b0; prevStall = 1'b0; prevData = '0;
    forever begin
      @(posedge i_clk); #1;
      if (prevStall && !engKill) begin
        checkOutput("hold_valid", o_out_valid, 1);
        checkOutput("hold_data", o_out_data, prevData);
      end
      rdy = (readyMode == 0) ? 1'b1 : (readyMode == 1) ? 1'($urandom_range(0, 1)) : !i_out_ready;
      i_out_ready = rdy;
      prevStall = o_out_valid && !rdy && !engKill;
      prevData  = o_out_data;
      if (o_out_valid && rdy && !engKill) begin
        if (expQ.size() == 0) begin
          testsRun++; testsFailed++;
          $display("[TB] FAIL unexpected_pixel: got %0h, expected no pixel", o_out_data);
        end else begin
          r = expQ.pop_front();
          testsRun++;
          if (o_out_data !== r.data || o_out_last !== r.last || o_out_filter_idx !== 16'(r.filt)) begin
            testsFailed++;
            $display("[TB] FAIL pixel %0d: got data=%h last=%b filt=%0d, expected data=%h last=%b filt=%0d",
                     pixOut, o_out_data, o_out_last, o_out_filter_idx, r.data, r.last, r.filt);
          end
          pixOut++;
          lastOut = o_out_data;
        end
      end
    end
  end

  task automatic checkResetState(input string name);
    checkOutput({name, "_ctrl"}, {o_busy, o_done, o_error, o_eng_start, o_out_valid, o_out_last}, 0);
    checkOutput({name, "_idx"}, {o_eng_map_idx, o_eng_filter_idx, o_out_filter_idx}, 0);
  endtask

  task automatic applyReset();
    engKill = 1'b1;
    expQ.delete();
    i_start = 1'b0;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic releaseReset();
    i_reset = 1'b0;
    repeat (2) begin @(posedge i_clk); #1; end
  endtask

  task automatic applyStimulus(input int n, input int k, input int m, input int f);
    cfgM = m; cfgF = f;
    cfgP2 = (k >= 1 && k <= n) ? (n - k + 1) * (n - k + 1) : 0;
    expPair = 0; engStarts = 0; engPix = 0; pixOut = 0; firstStartCyc = -1;
    expQ.delete();
    engKill = 1'b0;
    i_imageSize = 16'(n); i_filterSize = 16'(k); i_numMaps = 16'(m); i_numFilters = 16'(f);
    startCyc = cyc;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic finishLayer(input string name, input int expErr, input int expStarts, input int expPix);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 20000) begin
      if (o_done) seen = 1'b1;
      else begin @(posedge i_clk); #1; n++; end
    end
    checkOutput({name, "_done_seen"}, seen, 1);
    if (seen) begin
      checkOutput({name, "_error"}, o_error, expErr);
      checkOutput({name, "_busy_at_done"}, o_busy, 1);
      checkOutput({name, "_queue_drained"}, expQ.size(), 0);
      @(posedge i_clk); #1;
      checkOutput({name, "_done_pulse_idle"}, {o_done, o_busy}, 0);
      checkOutput({name, "_error_sticky"}, o_error, expErr);
    end else begin
      applyReset();
      releaseReset();
    end
    checkOutput({name, "_eng_starts"}, engStarts, expStarts);
    checkOutput({name, "_pixels_out"}, pixOut, expPix);
    if (expStarts > 0) checkOutput({name, "_start_latency"}, firstStartCyc - startCyc, 2);
  endtask

  task automatic runVector(input vecT v, input string name);
    pixOverride = v.ovr; dataMode = v.mode; readyMode = v.rdy;
    for (int c = 0; c < 16; c++) patVal[c] = (c + 1) * v.step;
    applyStimulus(v.n, v.k, v.m, v.f);
    finishLayer(name, v.expErr, v.expStarts, v.expPix);
    if (v.chkLast) checkOutput({name, "_value"}, lastOut, v.expLast);
  endtask

  initial begin
    int n, k, m, f, waitN;
    i_reset = 1'b1; i_start = 1'b0; engKill = 1'b1;
    i_imageSize = '0; i_filterSize = '0; i_numMaps = '0; i_numFilters = '0;
    pixOverride = -1; dataMode = 0; readyMode = 0; cfgM = 1; cfgF = 1; cfgP2 = 0;
    lastOut = '0;
    repeat (2) @(posedge i_clk);
    #1;
    checkResetState("reset_initial");
    releaseReset();

    //            n  k  m  f  ovr mode step   rdy err st  pix  last     chk
    vecs.push_back('{6, 3, 1, 1, -1, 1, 'h0400, 0, 0, 1, 16, 16'h0400, 1});
    vecs.push_back('{6, 3, 3, 2, -1, 1, 'h0100, 1, 0, 6, 32, 16'h0600, 1});
    vecs.push_back('{6, 3, 2, 2, -1, 1, 'h0100, 2, 0, 4, 32, 16'h0300, 1});
    vecs.push_back('{6, 7, 1, 1, -1, 0, 0, 0, 1, 0, 0, 16'h0, 0});
    vecs.push_back('{6, 0, 1, 1, -1, 0, 0, 0, 1, 0, 0, 16'h0, 0});
    vecs.push_back('{33, 3, 1, 1, -1, 0, 0, 0, 1, 0, 0, 16'h0, 0});
    vecs.push_back('{6, 6, 1, 1, -1, 0, 0, 0, 1, 0, 0, 16'h0, 0});
    vecs.push_back('{6, 3, 0, 1, -1, 0, 0, 0, 1, 0, 0, 16'h0, 0});
    vecs.push_back('{6, 3, 17, 1, -1, 0, 0, 0, 1, 0, 0, 16'h0, 0});
    vecs.push_back('{6, 3, 1, 0, -1, 0, 0, 0, 1, 0, 0, 16'h0, 0});
    vecs.push_back('{6, 3, 1, 17, -1, 0, 0, 0, 1, 0, 0, 16'h0, 0});
    vecs.push_back('{5, 5, 2, 3, -1, 0, 0, 1, 0, 6, 3, 16'h0, 0});
    vecs.push_back('{32, 5, 1, 1, -1, 0, 0, 1, 0, 1, 784, 16'h0, 0});
    vecs.push_back('{4, 4, 16, 1, -1, 0, 0, 1, 0, 16, 1, 16'h0, 0});
    vecs.push_back('{4, 3, 1, 16, -1, 0, 0, 2, 0, 16, 64, 16'h0, 0});
    vecs.push_back('{6, 3, 1, 1, 15, 0, 0, 0, 1, 1, 0, 16'h0, 0});
    vecs.push_back('{6, 3, 2, 1, 17, 0, 0, 1, 1, 2, 16, 16'h0, 0});
    vecs.push_back('{6, 3, 1, 1, -1, 1, 'h0123, 0, 0, 1, 16, 16'h0123, 1});
    foreach (vecs[i]) runVector(vecs[i], $sformatf("vec%0d", i));

    // Saturation toward +max, with a bad-config start pulse while busy that must be ignored.
    pixOverride = -1; dataMode = 1; readyMode = 0;
    patVal[0] = 'h7000; patVal[1] = 'h7000;
    applyStimulus(6, 3, 2, 1);
    i_filterSize = 16'd0; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    finishLayer("sat_pos", 0, 2, 16);
    checkOutput("sat_pos_value", lastOut, 16'h7FFF);

    patVal[0] = 'hA000; patVal[1] = 'hA000;
    applyStimulus(6, 3, 2, 1);
    finishLayer("sat_neg", 0, 2, 16);
    checkOutput("sat_neg_value", lastOut, 16'h8000);

    // Reset in the middle of RUN, then a clean layer.
    dataMode = 0; readyMode = 0;
    applyStimulus(6, 3, 2, 1);
    waitN = 0;
    while (engPix < 5 && waitN < 200) begin @(posedge i_clk); #1; waitN++; end
    checkOutput("mid_run_reached", engPix >= 5, 1);
    applyReset();
    checkResetState("reset_mid_run");
    releaseReset();
    dataMode = 1;
    for (int c = 0; c < 16; c++) patVal[c] = (c + 1) * 'h0100;
    applyStimulus(6, 3, 3, 2);
    finishLayer("after_run_reset", 0, 6, 32);
    checkOutput("after_run_reset_value", lastOut, 16'h0600);

    // Reset in the middle of DRAIN, then a clean layer.
    dataMode = 0; readyMode = 2;
    applyStimulus(6, 3, 1, 2);
    waitN = 0;
    while (pixOut < 3 && waitN < 400) begin @(posedge i_clk); #1; waitN++; end
    checkOutput("mid_drain_reached", pixOut >= 3, 1);
    applyReset();
    checkResetState("reset_mid_drain");
    releaseReset();
    dataMode = 1; readyMode = 1;
    applyStimulus(6, 3, 1, 1);
    finishLayer("after_drain_reset", 0, 1, 16);
    checkOutput("after_drain_reset_value", lastOut, 16'h0100);

    // Random legal layers with random data and random backpressure.
    pixOverride = -1; dataMode = 0;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(3, 10);
      k = $urandom_range(1, (n < 5) ? n : 5);
      m = $urandom_range(1, 4);
      f = $urandom_range(1, 3);
      readyMode = $urandom_range(0, 2);
      applyStimulus(n, k, m, f);
      finishLayer($sformatf("rand%0d", t), 0, m * f, f * (n - k + 1) * (n - k + 1));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
